// File: rtl/tcp_retx_queue_pkg.sv
// Shared types, defaults and mod-2^32 sequence helpers for the retransmission queue.
package tcp_retx_queue_pkg;

  localparam int unsigned RTO_INIT_DEF    = 200;
  localparam int unsigned RTO_MAX_DEF     = 6400;
  localparam int unsigned MAX_RETRIES_DEF = 5;
  localparam int unsigned RETRY_W         = 8;

  // TCP flag bit positions within the 8-bit flags byte
  localparam int unsigned FLAG_FIN = 0;
  localparam int unsigned FLAG_SYN = 1;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] end_seq;
    logic [15:0] len;
    logic [7:0]  flags;
  } retx_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RETX  = 2'd1,
    ABORT = 2'd2
  } retx_state_t;

  function automatic logic seq_lt(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return d[31];
  endfunction

  function automatic logic seq_le(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || seq_lt(a, b);
  endfunction

  // SYN and FIN each consume one unit of sequence space
  function automatic logic [31:0] seg_len(input logic [15:0] len, input logic [7:0] flags);
    return {16'd0, len} + {31'd0, flags[FLAG_SYN]} + {31'd0, flags[FLAG_FIN]};
  endfunction

endpackage

// File: rtl/tcp_retx_queue_rto.sv
// Retransmission timer: RTO value with exponential backoff, tick countdown, retry counter.
module tcp_rto_timer
  import tcp_retx_queue_pkg::*;
#(
  parameter int unsigned TIMER_W  = 16,
  parameter int unsigned RTO_INIT = RTO_INIT_DEF,
  parameter int unsigned RTO_MAX  = RTO_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic               progress,
  input  logic               keep,
  input  logic               backoff,
  output logic               expire,
  output logic [RETRY_W-1:0] retries
);

  localparam logic [TIMER_W-1:0] RTO_INIT_V = TIMER_W'(RTO_INIT);
  localparam logic [TIMER_W-1:0] RTO_MAX_V  = TIMER_W'(RTO_MAX);

  logic [TIMER_W-1:0] rto;
  logic [TIMER_W-1:0] timer;
  logic               running;
  logic [TIMER_W:0]   rto_dbl;
  logic [TIMER_W-1:0] rto_next;

  // doubling carried one bit wider so the ceiling compare never sees a wrapped value
  assign rto_dbl  = {rto, 1'b0};
  assign rto_next = (rto_dbl > {1'b0, RTO_MAX_V}) ? RTO_MAX_V : rto_dbl[TIMER_W-1:0];
  assign expire   = tick & running & (timer == TIMER_W'(1));

  // progress beats backoff beats arming beats countdown; expiry leaves the timer stopped
  always_ff @(posedge clk) begin
    if (rst) begin
      rto     <= RTO_INIT_V;
      timer   <= '0;
      running <= 1'b0;
      retries <= '0;
    end else if (progress) begin
      rto     <= RTO_INIT_V;
      retries <= '0;
      timer   <= keep ? RTO_INIT_V : '0;
      running <= keep;
    end else if (backoff) begin
      retries <= retries + RETRY_W'(1);
      rto     <= rto_next;
      timer   <= rto_next;
      running <= 1'b1;
    end else if (load) begin
      timer   <= rto;
      running <= 1'b1;
    end else if (tick && running) begin
      timer <= timer - TIMER_W'(1);
      if (timer == TIMER_W'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/tcp_retx_queue.sv
// Per-connection retransmission queue: ring of unacked segments, cumulative-ACK release,
// RTO-driven re-presentation of the head segment and abort after too many retries.
//
//  state | meaning
//  IDLE  | waiting for pushes/acks; timer may be running
//  RETX  | head segment presented on retx_*, pops held off until retx_ready
//  ABORT | retries exhausted; sticky until rst/clear
module tcp_retx_queue
  import tcp_retx_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PADDR_W     = 2,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned RTO_INIT    = RTO_INIT_DEF,
  parameter int unsigned RTO_MAX     = RTO_MAX_DEF,
  parameter int unsigned MAX_RETRIES = MAX_RETRIES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     timer_tick,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_seq,
  input  logic [15:0]              push_len,
  input  logic [7:0]               push_flags,
  input  logic [PADDR_W-1:0]       push_paddr,
  input  logic                     ack_valid,
  input  logic [31:0]              ack_num,
  output logic                     retx_valid,
  input  logic                     retx_ready,
  output logic [31:0]              retx_seq,
  output logic [15:0]              retx_len,
  output logic [7:0]               retx_flags,
  output logic [PADDR_W-1:0]       retx_paddr,
  output logic                     free_valid,
  output logic [PADDR_W-1:0]       free_paddr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     abort
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  retx_entry_t        ring       [DEPTH];
  logic [PADDR_W-1:0] ring_paddr [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [31:0]        ack_reg, snd_nxt;
  logic               ack_seen;
  retx_state_t        state_q, state_d;
  retx_entry_t        head;
  logic               rst_all, full, empty, push_fire, pop, ack_take;
  logic               keep, timer_load, handshake, expire, expire_now;
  logic [RETRY_W-1:0] retries;

  assign rst_all    = rst | clear;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign head       = ring[rd_ptr[IDX_W-1:0]];
  assign push_ready = !full && (state_q != ABORT) && !rst_all;
  assign push_fire  = push_valid && push_ready;
  // ack_seen keeps the reset value of ack_reg from releasing anything before a real ACK arrives
  assign pop        = !empty && (state_q != RETX) && ack_seen && !seq_lt(ack_reg, head.end_seq);
  assign ack_take   = ack_valid && (!ack_seen ||
                      (seq_lt(ack_reg, ack_num) && !seq_lt(snd_nxt, ack_num)));
  assign keep       = pop && ((count > PTR_W'(1)) || push_fire);
  assign timer_load = push_fire && empty;
  assign handshake  = (state_q == RETX) && retx_ready;
  assign expire_now = expire && !pop && (state_q == IDLE);

  assign retx_valid = (state_q == RETX);
  assign abort      = (state_q == ABORT);
  assign retx_seq   = head.seq;
  assign retx_len   = head.len;
  assign retx_flags = head.flags;
  assign retx_paddr = ring_paddr[rd_ptr[IDX_W-1:0]];

  tcp_rto_timer #(
    .TIMER_W  (TIMER_W),
    .RTO_INIT (RTO_INIT),
    .RTO_MAX  (RTO_MAX)
  ) u_rto (
    .clk      (clk),
    .rst      (rst_all),
    .tick     (timer_tick),
    .load     (timer_load),
    .progress (pop),
    .keep     (keep),
    .backoff  (handshake),
    .expire   (expire),
    .retries  (retries)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst_all) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state: expiry either retransmits or gives up, handshake returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (expire_now) state_d = (retries == RETRY_W'(MAX_RETRIES)) ? ABORT : RETX;
      RETX:    if (retx_ready) state_d = IDLE;
      ABORT:   state_d = ABORT;
      default: state_d = IDLE;
    endcase
  end

  // ring storage; contents are don't-care outside the occupied window so no reset
  always_ff @(posedge clk) begin
    if (push_fire) begin
      ring[wr_ptr[IDX_W-1:0]]       <= '{seq:     push_seq,
                                         end_seq: push_seq + seg_len(push_len, push_flags),
                                         len:     push_len,
                                         flags:   push_flags};
      ring_paddr[wr_ptr[IDX_W-1:0]] <= push_paddr;
    end
  end

  // pointers, sequence tracking and the free pulse
  always_ff @(posedge clk) begin
    if (rst_all) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ack_reg    <= '0;
      ack_seen   <= 1'b0;
      snd_nxt    <= '0;
      free_valid <= 1'b0;
      free_paddr <= '0;
    end else begin
      free_valid <= pop;
      if (push_fire) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        snd_nxt <= push_seq + seg_len(push_len, push_flags);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        free_paddr <= ring_paddr[rd_ptr[IDX_W-1:0]];
      end
      if (ack_take) begin
        ack_reg  <= ack_num;
        ack_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcp_retx_queue.sv
// Scoreboard bench for tcp_retx_queue: directed scenarios then randomized traffic,
// checked against a segment-list reference model.
module tb_tcp_retx_queue;

  localparam int DEPTH = 4;
  localparam int RTO_I = 4;
  localparam int RTO_M = 64;
  localparam int MAXR  = 2;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] endv;
    logic [15:0] len;
    logic [7:0]  flags;
    logic [1:0]  paddr;
  } seg_t;

  logic        clk;
  logic        d_rst, d_clear, d_tick, d_pv, d_av, d_rr;
  logic [31:0] d_seq, d_an;
  logic [15:0] d_len;
  logic [7:0]  d_flags;
  logic [1:0]  d_paddr;
  logic        push_ready, retx_valid, free_valid, abort;
  logic [31:0] retx_seq;
  logic [15:0] retx_len;
  logic [7:0]  retx_flags;
  logic [1:0]  retx_paddr, free_paddr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  // reference model
  seg_t        q[$];
  logic [31:0] m_ack, m_snd;
  bit          m_seen;
  int          m_timer, m_rto, m_retries;
  int          m_mode;   // 0 normal, 1 retransmit outstanding, 2 aborted
  logic [1:0]  exp_free[$];
  seg_t        exp_retx[$];

  tcp_retx_queue #(.DEPTH(DEPTH), .PADDR_W(2), .TIMER_W(16),
                   .RTO_INIT(RTO_I), .RTO_MAX(RTO_M), .MAX_RETRIES(MAXR)) dut (
    .clk(clk), .rst(d_rst), .clear(d_clear), .timer_tick(d_tick),
    .push_valid(d_pv), .push_ready(push_ready), .push_seq(d_seq), .push_len(d_len),
    .push_flags(d_flags), .push_paddr(d_paddr),
    .ack_valid(d_av), .ack_num(d_an),
    .retx_valid(retx_valid), .retx_ready(d_rr), .retx_seq(retx_seq), .retx_len(retx_len),
    .retx_flags(retx_flags), .retx_paddr(retx_paddr),
    .free_valid(free_valid), .free_paddr(free_paddr), .count(count), .abort(abort));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic bit lt(logic [31:0] a, logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return d[31];
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return (q.size() < DEPTH) && (m_mode != 2) && !d_rst && !d_clear;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ack = 0; m_snd = 0; m_seen = 0;
    m_timer = 0; m_rto = RTO_I; m_retries = 0; m_mode = 0;
  endtask

  // advance the model by one clock edge using the inputs that were applied for it
  task automatic model_step();
    bit push, pop, hs, was_empty;
    logic [31:0] old_snd, slen;
    if (d_rst || d_clear) begin
      model_reset();
      exp_retx.delete();
      return;
    end
    old_snd   = m_snd;
    was_empty = (q.size() == 0);
    push = d_pv && model_ready();
    pop  = (q.size() > 0) && (m_mode != 1) && m_seen && !lt(m_ack, q[0].endv);
    hs   = (m_mode == 1) && d_rr;
    if (pop) begin
      exp_free.push_back(q[0].paddr);
      void'(q.pop_front());
      m_retries = 0;
      m_rto = RTO_I;
      m_timer = (q.size() > 0 || push) ? RTO_I : 0;
    end else if (hs) begin
      m_retries++;
      m_rto = (2 * m_rto > RTO_M) ? RTO_M : 2 * m_rto;
      m_timer = m_rto;
      m_mode = 0;
    end else if (push && was_empty) begin
      m_timer = m_rto;
    end else if (d_tick && m_timer > 0) begin
      if (m_timer == 1) begin
        m_timer = 0;
        if (m_mode == 0) begin
          if (m_retries == MAXR) m_mode = 2;
          else begin
            m_mode = 1;
            exp_retx.push_back(q[0]);
          end
        end
      end else m_timer--;
    end
    if (push) begin
      slen = 32'(d_len) + (d_flags[1] ? 32'd1 : 32'd0) + (d_flags[0] ? 32'd1 : 32'd0);
      q.push_back('{seq: d_seq, endv: d_seq + slen, len: d_len, flags: d_flags, paddr: d_paddr});
      m_snd = d_seq + slen;
    end
    if (d_av && (!m_seen || (lt(m_ack, d_an) && !lt(old_snd, d_an)))) begin
      m_ack = d_an;
      m_seen = 1;
    end
  endtask

  // one clock with the currently driven inputs; pulses drop afterwards
  task automatic cyc();
    #1;
    chk("push_ready", 64'(push_ready), 64'(model_ready()));
    @(posedge clk);
    #1;
    model_step();
    chk("count", 64'(count), 64'(q.size()));
    chk("abort", 64'(abort), 64'(m_mode == 2));
    chk("retx_valid", 64'(retx_valid), 64'(m_mode == 1));
    d_pv = 0; d_av = 0; d_tick = 0; d_rst = 0; d_clear = 0;
  endtask

  task automatic push(logic [31:0] s, logic [15:0] l, logic [7:0] f, logic [1:0] p);
    d_pv = 1; d_seq = s; d_len = l; d_flags = f; d_paddr = p;
    cyc();
  endtask

  task automatic ack(logic [31:0] n);
    d_av = 1; d_an = n;
    cyc();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick_until(int mode, string name);
    int budget;
    budget = 200;
    while (m_mode != mode && budget > 0) begin
      d_tick = 1;
      cyc();
      budget--;
    end
    if (m_mode != mode) chk(name, 64'(m_mode), 64'(mode));
  endtask

  // monitor: pops expected frees/retransmits whenever the DUT presents them
  initial begin
    logic [1:0] ef;
    seg_t er;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (exp_free.size() > 0) begin
        ef = exp_free.pop_front();
        chk("free_valid", 64'(free_valid), 64'd1);
        chk("free_paddr", 64'(free_paddr), 64'(ef));
      end else if (free_valid !== 1'b0) begin
        chk("free_unexpected", 64'(free_valid), 64'd0);
      end
      if (retx_valid === 1'b1 && d_rr === 1'b1) begin
        if (exp_retx.size() == 0) chk("retx_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_retx.pop_front();
          chk("retx_fields", {6'd0, retx_seq, retx_len, retx_flags, retx_paddr},
              {6'd0, er.seq, er.len, er.flags, er.paddr});
        end
      end
    end
  end

  initial begin
    int r;
    d_rst = 1; d_clear = 0; d_tick = 0; d_pv = 0; d_av = 0; d_rr = 0;
    d_seq = 0; d_an = 0; d_len = 0; d_flags = 0; d_paddr = 0;
    model_reset();
    cyc();
    d_rst = 1;
    cyc();
    mon_en = 1;

    // two segments, one cumulative ack drains both
    push(1000, 100, 8'h10, 0);
    push(1100, 50, 8'h10, 1);
    ack(1150);
    idle(3);

    // partial ack, then expiry/backoff until abort, then clear
    d_clear = 1; cyc();
    push(1000, 100, 8'h10, 2);
    ack(1050);
    idle(2);
    tick_until(1, "first_expiry");
    idle(3);
    d_rr = 1; cyc(); d_rr = 0;
    tick_until(1, "second_expiry");
    d_rr = 1; cyc(); d_rr = 0;
    tick_until(2, "abort_expiry");
    d_pv = 1; d_seq = 5000; d_len = 10; cyc();
    d_clear = 1; cyc();
    idle(1);

    // sequence wrap and a stale ack afterwards
    push(32'hFFFF_FFF0, 16'h20, 8'h10, 3);
    ack(32'h10);
    idle(2);
    ack(32'hFFFF_FFF8);
    push(32'h10, 0, 8'h10, 1);
    idle(3);

    // full ring, release one, then push and pop together
    d_clear = 1; cyc();
    for (int i = 0; i < DEPTH; i++) push(32'(i * 100), 100, 8'h10, 2'(i));
    d_pv = 1; d_seq = 400; d_len = 100; d_flags = 8'h10; d_paddr = 0; cyc();
    ack(100);
    idle(1);
    d_av = 1; d_an = 300; cyc();
    push(400, 100, 8'h10, 0);
    push(500, 100, 8'h10, 1);
    idle(3);

    // SYN consumes one; ack beyond snd_nxt ignored; rst while retransmitting
    d_clear = 1; cyc();
    push(500, 0, 8'h02, 1);
    ack(501);
    idle(2);
    push(501, 100, 8'h10, 2);
    ack(9999);
    idle(2);
    ack(601);
    idle(2);
    push(700, 10, 8'h01, 3);
    tick_until(1, "pre_rst_expiry");
    idle(1);
    d_rst = 1; cyc();
    idle(2);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      d_tick = ($urandom_range(0, 3) == 0);
      d_rr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        d_pv = 1;
        d_len = 16'($urandom_range(0, 200));
        r = $urandom_range(0, 9);
        d_flags = (r == 0) ? 8'h02 : (r == 1) ? 8'h11 : 8'h10;
        d_paddr = 2'($urandom);
        d_seq = (q.size() == 0 && !m_seen) ? $urandom : m_snd;
      end
      if ($urandom_range(0, 4) == 0) begin
        d_av = 1;
        if ($urandom_range(0, 7) == 0) d_an = $urandom;
        else if (q.size() > 0) d_an = q[0].seq + $urandom_range(0, m_snd - q[0].seq);
        else d_an = m_snd - $urandom_range(0, 50);
      end
      if ($urandom_range(0, 399) == 0 || (m_mode == 2 && $urandom_range(0, 19) == 0)) d_clear = 1;
      cyc();
    end
    d_rr = 0;
    idle(3);
    chk("free_leftover", 64'(exp_free.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
